fetch_stage: RTL and testbench

Instruction fetch (IF) stage: owns the PC, issues word reads to instruction memory, and buffers returned words in order. It presents each word with its PC to decoder_stage over a valid/stall interface. It is the producer end of the `instruction` input that decoder_stage consumes, and it accepts branch/jump redirects from later stages.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: data width, NOP encoding, default reset PC, fetch FSM states
// and the {pc, instruction} entry held by the fetch buffer.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {pc, instruction} entries. A clear that coincides with
// a push leaves exactly the pushed entry in the buffer.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(push);
      count  <= CW'(push);
      if (push) mem[0] <= wdata;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, credit-limited memory requests, in-order word buffer.
// FETCH_ALIGN_CHECK_EN adds if_misaligned and the HALT-on-misaligned-redirect path.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instruction,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            if_misaligned
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] pc, resp_pc, target;
  logic [CW-1:0]   outstanding, drop_cnt, drop_next, fifo_count;
  logic [CW:0]     credits;
  logic            misaligned, pop, req_fire, resp_keep, fifo_push, fifo_full, fifo_empty;
  fetch_entry_t    head, wr_entry;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = |redirect_pc[1:0];
  assign target     = redirect_pc;
`else
  assign misaligned = 1'b0;
  assign target     = redirect_pc & ~32'h3;
`endif

  assign pop      = if_valid & ~stall & ~redirect_valid;
  // Credits cover both in-flight requests and buffered words, so a response always has a slot.
  assign credits  = (CW+1)'(outstanding) + (CW+1)'(fifo_count) - (CW+1)'(pop);
  assign imem_req_valid = ~rst & ~redirect_valid & (state != HALT) & (credits < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign resp_keep = imem_resp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign drop_next = outstanding - CW'(imem_resp_valid);
  assign fifo_push = resp_keep | (redirect_valid & misaligned);

  always_comb begin
    wr_entry = '{pc: resp_pc, instr: imem_resp_data};
    if (redirect_valid) wr_entry = '{pc: target, instr: NOP_INSTR};
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (pop),
    .clear (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        pc       <= target;
        resp_pc  <= target;
        drop_cnt <= drop_next;
        if (misaligned)            state <= HALT;
        else if (drop_next != '0)  state <= DRAIN;
        else                       state <= RUN;
      end else begin
        if (req_fire)  pc      <= pc + 32'd4;
        if (resp_keep) resp_pc <= resp_pc + 32'd4;
        if (imem_resp_valid && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
          if (state == DRAIN && drop_cnt == CW'(1)) state <= RUN;
        end
      end
    end
  end

  assign if_valid       = ~fifo_empty;
  assign if_pc          = if_valid ? head.pc : '0;
  assign if_instruction = if_valid ? head.instr : '0;
  assign if_pc_plus4    = if_valid ? head.pc + 32'd4 : '0;
`ifdef FETCH_ALIGN_CHECK_EN
  assign if_misaligned  = if_valid & (state == HALT);
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model with random ready/latency, expected
// instruction stream generated from PC rules, monitor compares each accepted word.
`timescale 1ns/1ps
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instruction, if_pc, if_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        if_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
    , .if_misaligned(if_misaligned)
`endif
  );

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, popped = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h007302b3;
      32'h4:   return 32'h00a48433;
      32'h8:   return 32'h00530293;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model: in-order responses ----------------
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    mode = 0, lat = 0, last_due = 0, d, due;
  logic  first_req_chk = 1'b0;

  always @(negedge clk) if (!rst) begin
    if (imem_req_valid && imem_req_ready) begin
      d   = (mode == 2) ? int'($urandom_range(0, 4)) : lat;
      due = cyc + 1 + d;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{imem_req_addr, due});
      if (first_req_chk) begin
        check("first_req_after_reset", imem_req_addr, 32'h0);
        first_req_chk = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      mq.delete();
      last_due = 0;
      imem_resp_valid = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    imem_req_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- expected stream + monitor ----------------
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } exp_t;
  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] gen_pc = 32'h0;
  logic        halted = 1'b0;
  logic        held_v = 1'b0;
  logic [31:0] held_pc, held_ins;

  always @(negedge clk) if (!rst) begin
    if (held_v) begin
      check("stall_hold_valid", {31'b0, if_valid}, 32'h1);
      check("stall_hold_pc", if_pc, held_pc);
      check("stall_hold_instr", if_instruction, held_ins);
    end
    if (if_valid && !stall && !redirect_valid) begin
      if (exp_q.size() == 0 && !halted) begin
        exp_q.push_back('{gen_pc, mem_word(gen_pc), 1'b0});
        gen_pc += 32'd4;
      end
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_word: got pc %h, none expected", if_pc);
      end else begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_instruction", if_instruction, e.instr);
        check("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
        check("if_misaligned", {31'b0, if_misaligned}, {31'b0, e.mis});
`endif
        popped++;
      end
    end
    held_v   = if_valid && stall && !redirect_valid;
    held_pc  = if_pc;
    held_ins = if_instruction;
    if (imem_resp_valid && dut.drop_cnt == '0 && dut.fifo_full) begin
      n_cmp++; n_fail++;
      $display("FAIL fifo_overflow: response with full buffer at cycle %0d", cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic model_reset();
    exp_q.delete();
    gen_pc = 32'h0;
    halted = 1'b0;
    held_v = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    exp_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
    if (t[1:0] != 2'b00) begin
      exp_q.push_back('{t, NOP_INSTR, 1'b1});
      halted = 1'b1;
    end else begin
      gen_pc = t;
      halted = 1'b0;
    end
`else
    gen_pc = t & ~32'h3;
    halted = 1'b0;
`endif
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_inflight2();
    int n = 0;
    while (mq.size() != 2 && n < 100) begin @(posedge clk); #2; n++; end
    if (mq.size() != 2) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_inflight: pending %0d required 2", mq.size());
    end
  endtask

  task automatic run_expect(input int ncyc, input int min_pop, input string name);
    int p0 = popped;
    repeat (ncyc) @(posedge clk);
    #1;
    check(name, {31'b0, (popped - p0) >= min_pop}, 32'h1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int target, n;
    mode = 0; lat = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    first_req_chk = 1'b1;

    // Reset release: first word visible two cycles after the first request
    @(negedge clk);
    check("c0_if_valid", {31'b0, if_valid}, 32'h0);
    check("c0_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("c0_if_pc", if_pc, 32'h0);
    check("c0_if_pc_plus4", if_pc_plus4, 32'h0);
    @(negedge clk);
    check("c1_if_valid", {31'b0, if_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stream_if_valid", {31'b0, if_valid}, 32'h1);
      check("stream_if_pc", if_pc, 32'(4 * i));
      check("stream_if_pc_plus4", if_pc_plus4, 32'(4 * i + 4));
    end

    // Stall 5 cycles: head frozen, requests stop once credits are spent
    @(posedge clk); #1 stall = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stall_req_stopped", {31'b0, imem_req_valid}, 32'h0);
    @(posedge clk); #1 stall = 1'b0;
    run_expect(10, 8, "after_stall_progress");

    // Redirect with two requests in flight: stale words dropped
    mode = 1; lat = 2;
    wait_inflight2();
    redirect(32'h100);
    @(negedge clk);
    check("redirect_next_if_valid", {31'b0, if_valid}, 32'h0);
    run_expect(30, 4, "after_redirect_progress");

    // Back-to-back redirects: last one wins
    redirect(32'h200);
    redirect(32'h300);
    run_expect(30, 4, "back_to_back_progress");

`ifndef FETCH_ALIGN_CHECK_EN
    // Low target bits ignored without the alignment check
    redirect(32'h402);
    run_expect(30, 4, "unaligned_redirect_progress");
`endif

    // Random ready / latency / stall, 1000 instructions
    mode = 2;
    target = popped + 1000;
    n = 0;
    while (popped < target && n < 20000) begin
      @(posedge clk); #1;
      stall = ($urandom_range(0, 4) == 0);
      n++;
    end
    stall = 1'b0;
    check("random_1000_complete", {31'b0, popped >= target}, 32'h1);

    // Async reset mid-burst
    mode = 1; lat = 2;
    wait_inflight2();
    #1 rst = 1'b1;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_if_instruction", if_instruction, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    model_reset();
    mode = 0; lat = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    first_req_chk = 1'b1;
    run_expect(20, 10, "after_reset_progress");

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect: one NOP entry then halt until the next redirect
    redirect(32'h102);
    @(negedge clk);
    check("mis_if_valid", {31'b0, if_valid}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("halt_no_request", {31'b0, imem_req_valid}, 32'h0);
    end
    @(posedge clk); #1;
    redirect(32'h200);
    run_expect(20, 10, "resume_after_halt");
`endif

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
